// File: rtl/axil_wr_rd_checker.sv
// AXI4-Lite write/read-back checker (master).
//
// On a start pulse the block writes NUM_VECTORS data patterns to consecutive addresses
// and reads them back, comparing each read against the expected pattern. The two run
// modes are interleaved (W0 R0 W1 R1 ...) and phased (all writes, then all reads).
//
// Ports:
//   ACLK, ARESETN          clock, asynchronous active-low reset
//   start, mode            run request and run mode, sampled only when idle or done
//   busy, done, pass       run status; done/pass hold until the next start
//   err_count              saturating count of failed transactions
//   first_err_addr         address of the first failing transaction
//   timeout                (AXIL_CHK_TIMEOUT_EN only) a state outlived TIMEOUT_CYCLES
//   m_axi_*                AXI4-Lite master channels AW, W, B, AR, R
//
// Build option: define AXIL_CHK_TIMEOUT_EN to add the TIMEOUT_CYCLES parameter, the
// timeout output and the per-state watchdog counter.
module axil_wr_rd_checker #(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           NUM_VECTORS  = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int unsigned           ADDR_STRIDE  = DATA_WIDTH / 8,
    parameter logic [31:0]           PATTERN_SEED = 32'h0101FFFF
`ifdef AXIL_CHK_TIMEOUT_EN
    ,
    parameter int unsigned           TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    start,
    input  logic                    mode,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [7:0]              err_count,
    output logic [ADDR_WIDTH-1:0]   first_err_addr,
`ifdef AXIL_CHK_TIMEOUT_EN
    output logic                    timeout,
`endif
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam int unsigned IDX_W = $clog2(NUM_VECTORS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

    typedef enum logic [2:0] {StIdle, StWrReq, StWrResp, StRdReq, StRdResp, StDone} state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    mode_q, mode_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [7:0]              err_count_q, err_count_d;
    logic [ADDR_WIDTH-1:0]   first_err_addr_q, first_err_addr_d;
    logic                    pass_q, pass_d;
    logic                    err_inc;
`ifdef AXIL_CHK_TIMEOUT_EN
    logic [31:0]             tmo_cnt_q, tmo_cnt_d;
    logic                    timeout_q, timeout_d;
`endif

    logic [31:0]             pattern;
    logic [DATA_WIDTH-1:0]   exp_data;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic                    aw_hs, w_hs;

    // Pattern arithmetic is 32-bit regardless of DATA_WIDTH, then zero-extended.
    assign pattern  = PATTERN_SEED + 32'(idx_q) * 32'h01010101;
    assign cur_addr = BASE_ADDR + ADDR_WIDTH'(idx_q) * ADDR_WIDTH'(ADDR_STRIDE);

    always_comb begin
        exp_data       = '0;
        exp_data[31:0] = pattern;
    end

    assign aw_hs = m_axi_awvalid && m_axi_awready;
    assign w_hs  = m_axi_wvalid && m_axi_wready;

    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        mode_d           = mode_q;
        aw_done_d        = aw_done_q;
        w_done_d         = w_done_q;
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;
        pass_d           = pass_q;
        err_inc          = 1'b0;
`ifdef AXIL_CHK_TIMEOUT_EN
        tmo_cnt_d        = '0;
        timeout_d        = timeout_q;
`endif

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d          = StWrReq;
                    idx_d            = '0;
                    mode_d           = mode;
                    aw_done_d        = 1'b0;
                    w_done_d         = 1'b0;
                    err_count_d      = '0;
                    first_err_addr_d = '0;
                    pass_d           = 1'b0;
`ifdef AXIL_CHK_TIMEOUT_EN
                    timeout_d        = 1'b0;
`endif
                end
            end
            StWrReq: begin
                // AW and W complete independently; leave once both have handshaken.
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d   = StWrResp;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            StWrResp: begin
                if (m_axi_bvalid) begin
                    err_inc = (m_axi_bresp != 2'b00);
                    if (!mode_q) begin
                        state_d = StRdReq;
                    end else if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = StRdReq;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = StWrReq;
                    end
                end
            end
            StRdReq: begin
                if (m_axi_arready) begin
                    state_d = StRdResp;
                end
            end
            StRdResp: begin
                if (m_axi_rvalid) begin
                    err_inc = (m_axi_rresp != 2'b00) || (m_axi_rdata != exp_data);
                    if (idx_q == LAST_IDX) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = mode_q ? StRdReq : StWrReq;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef AXIL_CHK_TIMEOUT_EN
        // Watchdog counts cycles spent in the current busy state; any transition restarts it.
        if (busy && (state_d == state_q)) begin
            if (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                err_inc   = 1'b1;
                timeout_d = 1'b1;
                state_d   = StDone;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 32'd1;
            end
        end
`endif

        if (err_inc) begin
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
            if (err_count_q == 8'd0) begin
                first_err_addr_d = cur_addr;
            end
        end

        if ((state_d == StDone) && (state_q != StDone)) begin
            pass_d = (err_count_d == 8'd0);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q          <= StIdle;
            idx_q            <= '0;
            mode_q           <= 1'b0;
            aw_done_q        <= 1'b0;
            w_done_q         <= 1'b0;
            err_count_q      <= '0;
            first_err_addr_q <= '0;
            pass_q           <= 1'b0;
`ifdef AXIL_CHK_TIMEOUT_EN
            tmo_cnt_q        <= '0;
            timeout_q        <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            mode_q           <= mode_d;
            aw_done_q        <= aw_done_d;
            w_done_q         <= w_done_d;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
            pass_q           <= pass_d;
`ifdef AXIL_CHK_TIMEOUT_EN
            tmo_cnt_q        <= tmo_cnt_d;
            timeout_q        <= timeout_d;
`endif
        end
    end

    // Channel outputs decode from state so that reset (state = IDLE) zeroes them at once.
    assign m_axi_awvalid = (state_q == StWrReq) && !aw_done_q;
    assign m_axi_wvalid  = (state_q == StWrReq) && !w_done_q;
    assign m_axi_awaddr  = (state_q == StWrReq) ? cur_addr : '0;
    assign m_axi_wdata   = (state_q == StWrReq) ? exp_data : '0;
    assign m_axi_wstrb   = '1;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_bready  = (state_q == StWrResp);
    assign m_axi_arvalid = (state_q == StRdReq);
    assign m_axi_araddr  = (state_q == StRdReq) ? cur_addr : '0;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_rready  = (state_q == StRdResp);

    assign busy           = (state_q != StIdle) && (state_q != StDone);
    assign done           = (state_q == StDone);
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;
`ifdef AXIL_CHK_TIMEOUT_EN
    assign timeout        = timeout_q;
`endif

endmodule

// File: tb/tb_axil_wr_rd_checker.sv
// Directed bench for axil_wr_rd_checker with a small AXI4-Lite memory slave model.
module tb_axil_wr_rd_checker;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        busy, done, pass;
    logic [7:0]  err_count;
    logic [31:0] first_err_addr;
`ifdef AXIL_CHK_TIMEOUT_EN
    logic        timeout;
`endif
    logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;
    logic [1:0]  m_axi_bresp, m_axi_rresp;

    // Slave knobs and monitor clear, driven from the stimulus block.
    logic aw_delay_en = 1'b0;
    logic bad_bresp_en = 1'b0;
    logic corrupt_en = 1'b0;
    logic ar_stall = 1'b0;
    logic mon_clr = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 ACLK = ~ACLK;

    axil_wr_rd_checker #(
`ifdef AXIL_CHK_TIMEOUT_EN
        .TIMEOUT_CYCLES(16),
`endif
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .mode(mode),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr),
`ifdef AXIL_CHK_TIMEOUT_EN
        .timeout(timeout),
`endif
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    // ---------------- slave model ----------------
    logic [31:0] mem [16];
    logic        aw_got, w_got;
    logic [31:0] aw_addr_l, w_data_l;
    logic [1:0]  aw_cnt;

    assign m_axi_wready  = 1'b1;
    assign m_axi_awready = aw_delay_en ? (aw_cnt == 2'd3) : 1'b1;
    assign m_axi_arready = !ar_stall;

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_got <= 1'b0; w_got <= 1'b0; aw_addr_l <= '0; w_data_l <= '0; aw_cnt <= '0;
            m_axi_bvalid <= 1'b0; m_axi_bresp <= '0;
            m_axi_rvalid <= 1'b0; m_axi_rresp <= '0; m_axi_rdata <= '0;
        end else begin
            if (mon_clr) begin
                for (int i = 0; i < 16; i++) mem[i] <= '0;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                w_got <= 1'b1; w_data_l <= m_axi_wdata; aw_cnt <= 2'd1;
            end else if (aw_cnt != 2'd0 && aw_cnt != 2'd3) begin
                aw_cnt <= aw_cnt + 2'd1;
            end
            if (m_axi_awvalid && m_axi_awready) begin
                aw_got <= 1'b1; aw_addr_l <= m_axi_awaddr; aw_cnt <= 2'd0;
            end
            if (aw_got && w_got && !m_axi_bvalid) begin
                m_axi_bvalid <= 1'b1;
                m_axi_bresp  <= (bad_bresp_en && aw_addr_l == 32'h0) ? 2'b10 : 2'b00;
                mem[aw_addr_l[5:2]] <= w_data_l;
                aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
            if (m_axi_arvalid && m_axi_arready) begin
                m_axi_rvalid <= 1'b1;
                m_axi_rresp  <= 2'b00;
                m_axi_rdata  <= (corrupt_en && m_axi_araddr == 32'h8) ? 32'hDEAD0011
                                                                      : mem[m_axi_araddr[5:2]];
            end
            if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
        end
    end

    // ---------------- bus monitor ----------------
    int aw_hs_cnt, w_hs_cnt, ar_hs_cnt, aw_at_first_ar, aw_only_cyc, arv_cyc;

    always @(posedge ACLK) begin
        if (mon_clr) begin
            aw_hs_cnt <= 0; w_hs_cnt <= 0; ar_hs_cnt <= 0;
            aw_at_first_ar <= 0; aw_only_cyc <= 0; arv_cyc <= 0;
        end else begin
            if (m_axi_awvalid && m_axi_awready) aw_hs_cnt <= aw_hs_cnt + 1;
            if (m_axi_wvalid && m_axi_wready) w_hs_cnt <= w_hs_cnt + 1;
            if (m_axi_arvalid && m_axi_arready) begin
                ar_hs_cnt <= ar_hs_cnt + 1;
                if (ar_hs_cnt == 0) aw_at_first_ar <= aw_hs_cnt;
            end
            if (m_axi_awvalid && !m_axi_wvalid) aw_only_cyc <= aw_only_cyc + 1;
            if (m_axi_arvalid) arv_cyc <= arv_cyc + 1;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        @(negedge ACLK) mon_clr = 1'b1;
        @(negedge ACLK) mon_clr = 1'b0;
    endtask

    task automatic pulse_start(input logic m);
        @(negedge ACLK) begin start = 1'b1; mode = m; end
        @(negedge ACLK) begin start = 1'b0; mode = 1'b0; end
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge ACLK);
        end
        check(tag, ok, 1'b1);
    endtask

    task automatic run(input string tag, input logic m);
        clear_mon();
        pulse_start(m);
        check({tag, "_busy"}, busy, 1'b1);
        wait_done({tag, "_done"}, 300);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic ok;
        repeat (3) @(negedge ACLK);
        check("rst_ctrl", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                           m_axi_rready, busy, done, pass, err_count}, 64'h0);
        check("rst_first_err", first_err_addr, 64'h0);
        check("rst_addr", {m_axi_awaddr, m_axi_araddr}, 64'h0);
        check("rst_wdata", m_axi_wdata, 64'h0);
        check("prot_strb", {m_axi_awprot, m_axi_arprot, m_axi_wstrb}, 64'h00F);

        @(negedge ACLK) ARESETN = 1'b1;
        repeat (5) @(negedge ACLK);
        check("no_autostart", {busy, done, m_axi_awvalid}, 64'h0);

        // Interleaved run against an ideal memory.
        run("m0", 1'b0);
        check("m0_pass", {pass, err_count}, {56'h0, 1'b1, 8'h00});
        check("m0_busy_end", busy, 1'b0);
        check("m0_mem0", mem[0], 64'h0101FFFF);
        check("m0_mem1", mem[1], 64'h02030100);
        check("m0_mem2", mem[2], 64'h03040201);
        check("m0_mem3", mem[3], 64'h04050302);
        check("m0_order", aw_at_first_ar, 64'd1);
        check("m0_counts", {w_hs_cnt[7:0], ar_hs_cnt[7:0]}, 64'h0404);

        // Phased run: all four writes precede the first read.
        run("m1", 1'b1);
        check("m1_pass", {pass, err_count}, {56'h0, 1'b1, 8'h00});
        check("m1_order", aw_at_first_ar, 64'd4);
        check("m1_reads", ar_hs_cnt, 64'd4);
        check("m1_mem3", mem[3], 64'h04050302);

        // A start (with mode=1) while busy must not restart or change the mode.
        clear_mon();
        pulse_start(1'b0);
        @(negedge ACLK) begin start = 1'b1; mode = 1'b1; end
        @(negedge ACLK) begin start = 1'b0; mode = 1'b0; end
        wait_done("ign_done", 300);
        check("ign_order", aw_at_first_ar, 64'd1);
        check("ign_writes", w_hs_cnt, 64'd4);
        check("ign_pass", pass, 1'b1);

        // Corrupted read data at 0x8.
        corrupt_en = 1'b1;
        run("bad_rd", 1'b0);
        corrupt_en = 1'b0;
        check("bad_rd_err", err_count, 64'd1);
        check("bad_rd_addr", first_err_addr, 64'h8);
        check("bad_rd_pass", pass, 1'b0);

        // awready lags wready by 3 cycles; vector 0 gets SLVERR.
        aw_delay_en = 1'b1;
        bad_bresp_en = 1'b1;
        run("slverr", 1'b0);
        aw_delay_en = 1'b0;
        bad_bresp_en = 1'b0;
        check("slverr_err", err_count, 64'd1);
        check("slverr_addr", first_err_addr, 64'h0);
        check("slverr_pass", pass, 1'b0);
        check("slverr_wdrop", aw_only_cyc, 64'd12);
        check("slverr_writes", w_hs_cnt, 64'd4);

        // Reset in the middle of RD_RESP for vector 2.
        clear_mon();
        pulse_start(1'b0);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (ar_hs_cnt == 3) begin
                ok = 1'b1;
                break;
            end
            @(negedge ACLK);
        end
        check("mid_reach", ok, 1'b1);
        check("mid_rready", m_axi_rready, 1'b1);
        ARESETN = 1'b0;
        #1;
        check("mid_rst_ctrl", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                               m_axi_rready, busy, done, pass, err_count}, 64'h0);
        check("mid_rst_addr", {m_axi_awaddr, m_axi_araddr}, 64'h0);
        check("mid_rst_misc", {m_axi_wdata, first_err_addr}, 64'h0);
        @(negedge ACLK);
        @(negedge ACLK) ARESETN = 1'b1;
        run("after_rst", 1'b0);
        check("after_rst_pass", {pass, err_count}, {56'h0, 1'b1, 8'h00});

`ifdef AXIL_CHK_TIMEOUT_EN
        // AR never accepted: the watchdog ends the run after 16 RD_REQ cycles.
        ar_stall = 1'b1;
        run("tmo", 1'b0);
        check("tmo_flag", timeout, 1'b1);
        check("tmo_err", err_count, 64'd1);
        check("tmo_arv_cycles", arv_cyc, 64'd16);
        check("tmo_outputs", {m_axi_arvalid, m_axi_rready, pass}, 64'h0);
        ar_stall = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
